// File: rtl/decode_stage.sv
// RISC-V instruction decode stage: combinational field/immediate decode feeding
// a two-entry (main + skid) output buffer with valid/ready handshakes on both
// sides, flush, and a saturating count of illegal instructions delivered.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  dec_t             dec_c;
  logic [2:0]       fmt_c;

  state_t           state_q, state_d;
  dec_t             main_q, main_d;
  dec_t             skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;
  logic             deliver_c;

  // Classify the incoming word into a format (RV64-only opcodes gated by XLEN).
  always_comb begin
    fmt_c = FMT_ILL;
    case (in_instr[6:0])
      7'b0110011:                         fmt_c = FMT_R;
      7'b0111011:                         fmt_c = (XLEN == 64) ? FMT_R : FMT_ILL;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b0001111, 7'b1110011:             fmt_c = FMT_I;
      7'b0011011:                         fmt_c = (XLEN == 64) ? FMT_I : FMT_ILL;
      7'b0100011:                         fmt_c = FMT_S;
      7'b1100011:                         fmt_c = FMT_B;
      7'b0110111, 7'b0010111:             fmt_c = FMT_U;
      7'b1101111:                         fmt_c = FMT_J;
      default:                            fmt_c = FMT_ILL;
    endcase
    if (in_instr[1:0] != 2'b11) begin
      fmt_c = FMT_ILL;
    end
    if ((fmt_c == FMT_R) && !(in_instr[31:25] inside {7'b0000000, 7'b0100000, 7'b0000001})) begin
      fmt_c = FMT_ILL;
    end
  end

  // Extract fields and immediate for the classified format; unused fields stay zero.
  always_comb begin
    dec_c        = '0;
    dec_c.pc     = in_pc;
    dec_c.opcode = in_instr[6:0];
    dec_c.fmt    = fmt_c;
    case (fmt_c)
      FMT_R: begin
        dec_c.rd     = in_instr[11:7];
        dec_c.rs1    = in_instr[19:15];
        dec_c.rs2    = in_instr[24:20];
        dec_c.funct3 = in_instr[14:12];
        dec_c.funct7 = in_instr[31:25];
      end
      FMT_I: begin
        dec_c.rd     = in_instr[11:7];
        dec_c.rs1    = in_instr[19:15];
        dec_c.funct3 = in_instr[14:12];
        dec_c.imm    = XLEN'($signed(in_instr[31:20]));
      end
      FMT_S: begin
        dec_c.rs1    = in_instr[19:15];
        dec_c.rs2    = in_instr[24:20];
        dec_c.funct3 = in_instr[14:12];
        dec_c.imm    = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      FMT_B: begin
        dec_c.rs1    = in_instr[19:15];
        dec_c.rs2    = in_instr[24:20];
        dec_c.funct3 = in_instr[14:12];
        dec_c.imm    = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                      in_instr[11:8], 1'b0}));
      end
      FMT_U: begin
        dec_c.rd     = in_instr[11:7];
        dec_c.imm    = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      FMT_J: begin
        dec_c.rd     = in_instr[11:7];
        dec_c.imm    = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                      in_instr[30:21], 1'b0}));
      end
      default: begin
        dec_c.fmt     = FMT_ILL;
        dec_c.illegal = 1'b1;
      end
    endcase
  end

  // Buffer occupancy FSM: main always holds the oldest entry, skid refills it on delivery.
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    cnt_d     = cnt_q;
    accept_c  = in_valid && in_ready_q && !flush;
    deliver_c = out_valid_q && out_ready && !flush;

    case (state_q)
      S_EMPTY: begin
        if (accept_c) begin
          main_d  = dec_c;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept_c && deliver_c) begin
          main_d = dec_c;
        end else if (accept_c) begin
          skid_d  = dec_c;
          state_d = S_TWO;
        end else if (deliver_c) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (deliver_c) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (flush) begin
      state_d = S_EMPTY;
    end

    if (deliver_c && main_q.illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
  end

  // State, buffer entries, handshake flags and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = main_q.pc;
  assign out_opcode  = main_q.opcode;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_funct3  = main_q.funct3;
  assign out_funct7  = main_q.funct7;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32 instance (16-bit counter) and an
// RV64 instance (2-bit counter). Stimulus pushes hand-computed expectations,
// per-instance monitors pop and compare on every output handshake.
module tb_decode_stage;

  typedef struct {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic clock;
  logic reset_n;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_instr, a_in_pc, a_out_pc, a_out_imm;
  logic [6:0]  a_out_opcode, a_out_funct7;
  logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
  logic [2:0]  a_out_funct3, a_out_fmt;
  logic        a_out_illegal;
  logic [15:0] a_illegal_cnt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_instr;
  logic [63:0] b_in_pc, b_out_pc, b_out_imm;
  logic [6:0]  b_out_opcode, b_out_funct7;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
  logic [2:0]  b_out_funct3, b_out_fmt;
  logic        b_out_illegal;
  logic [1:0]  b_illegal_cnt;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  decode_stage #(.XLEN(32), .CNT_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
    .out_opcode(a_out_opcode), .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
    .out_funct3(a_out_funct3), .out_funct7(a_out_funct7), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .illegal_cnt(a_illegal_cnt)
  );

  decode_stage #(.XLEN(64), .CNT_W(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .out_opcode(b_out_opcode), .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
    .out_funct3(b_out_funct3), .out_funct7(b_out_funct7), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .illegal_cnt(b_illegal_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [2:0] fmt, input logic [6:0] opc,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [63:0] imm, input logic ill);
    exp_t e;
    e.pc = '0; e.opcode = opc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.f3 = f3; e.f7 = f7; e.imm = imm; e.fmt = fmt; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t mk_ill(input logic [6:0] opc);
    return mk(3'd7, opc, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Offer one instruction to the RV32 instance; expectation is queued when it will be taken.
  task automatic send_a(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    int n = 0;
    a_in_valid = 1'b1; a_in_instr = ins; a_in_pc = pc;
    while (!a_in_ready && n < 100) begin cyc(); n++; end
    if (!a_in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL a_send_timeout: in_ready stuck at 0 for instr 0x%08h", ins);
    end else begin
      e.pc = {32'd0, pc};
      q_a.push_back(e);
    end
    cyc();
  endtask

  task automatic send_b(input logic [31:0] ins, input logic [63:0] pc, input exp_t e);
    int n = 0;
    b_in_valid = 1'b1; b_in_instr = ins; b_in_pc = pc;
    while (!b_in_ready && n < 100) begin cyc(); n++; end
    if (!b_in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL b_send_timeout: in_ready stuck at 0 for instr 0x%08h", ins);
    end else begin
      e.pc = pc;
      q_b.push_back(e);
    end
    cyc();
  endtask

  task automatic drain_a();
    int n = 0;
    while (a_out_valid && n < 50) begin cyc(); n++; end
    check("a_drain_out_valid", 64'(a_out_valid), 64'd0);
  endtask

  task automatic drain_b();
    int n = 0;
    while (b_out_valid && n < 50) begin cyc(); n++; end
    check("b_drain_out_valid", 64'(b_out_valid), 64'd0);
  endtask

  // RV32 monitor: compare every delivered instruction against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (a_out_valid && a_out_ready) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected: delivery of pc 0x%0h with empty scoreboard", a_out_pc);
      end else begin
        e = q_a.pop_front();
        check("a_pc",      64'(a_out_pc),      e.pc);
        check("a_opcode",  64'(a_out_opcode),  64'(e.opcode));
        check("a_rd",      64'(a_out_rd),      64'(e.rd));
        check("a_rs1",     64'(a_out_rs1),     64'(e.rs1));
        check("a_rs2",     64'(a_out_rs2),     64'(e.rs2));
        check("a_funct3",  64'(a_out_funct3),  64'(e.f3));
        check("a_funct7",  64'(a_out_funct7),  64'(e.f7));
        check("a_imm",     64'(a_out_imm),     e.imm);
        check("a_fmt",     64'(a_out_fmt),     64'(e.fmt));
        check("a_illegal", 64'(a_out_illegal), 64'(e.ill));
      end
    end
  end

  // RV64 monitor.
  always @(negedge clock) begin
    exp_t e;
    if (b_out_valid && b_out_ready) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected: delivery of pc 0x%0h with empty scoreboard", b_out_pc);
      end else begin
        e = q_b.pop_front();
        check("b_pc",      b_out_pc,           e.pc);
        check("b_opcode",  64'(b_out_opcode),  64'(e.opcode));
        check("b_rd",      64'(b_out_rd),      64'(e.rd));
        check("b_rs1",     64'(b_out_rs1),     64'(e.rs1));
        check("b_rs2",     64'(b_out_rs2),     64'(e.rs2));
        check("b_funct3",  64'(b_out_funct3),  64'(e.f3));
        check("b_funct7",  64'(b_out_funct7),  64'(e.f7));
        check("b_imm",     b_out_imm,          e.imm);
        check("b_fmt",     64'(b_out_fmt),     64'(e.fmt));
        check("b_illegal", 64'(b_out_illegal), 64'(e.ill));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_instr = '0; a_in_pc = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 0;

    // Reset values.
    #1;
    check("rst_out_valid", 64'(a_out_valid),   64'd0);
    check("rst_in_ready",  64'(a_in_ready),    64'd0);
    check("rst_cnt",       64'(a_illegal_cnt), 64'd0);
    check("rst_out_pc",    64'(a_out_pc),      64'd0);
    check("rst_out_imm",   64'(a_out_imm),     64'd0);
    #21;
    reset_n = 1'b1;
    #1;
    check("rst_in_ready_before_edge", 64'(a_in_ready), 64'd0);
    cyc();
    check("rst_in_ready_after_edge", 64'(a_in_ready), 64'd1);

    // Streaming decode with downstream always ready.
    a_out_ready = 1'b1;
    send_a(32'hFFF00093, 32'h100, mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF, 1'b0));
    check("a_latency_out_valid", 64'(a_out_valid), 64'd1);
    send_a(32'hFE000EE3, 32'h104, mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFC, 1'b0));
    send_a(32'h402081B3, 32'h108, mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'd0, 1'b0));
    send_a(32'hFE20AC23, 32'h10C, mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 64'hFFFF_FFF8, 1'b0));
    send_a(32'h123452B7, 32'h110, mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000, 1'b0));
    send_a(32'h008000EF, 32'h114, mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h8, 1'b0));
    send_a(32'hFFDFF06F, 32'h118, mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFC, 1'b0));
    send_a(32'h00412283, 32'h11C, mk(3'd1, 7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 64'h4, 1'b0));
    send_a(32'h00000000, 32'h120, mk_ill(7'h00));
    a_in_valid = 1'b0;
    drain_a();
    check("a_cnt_first_illegal", 64'(a_illegal_cnt), 64'd1);

    // Illegal funct7, bad low bits, RV64-only opcode on RV32.
    send_a(32'h802081B3, 32'h124, mk_ill(7'h33));
    send_a(32'h00000091, 32'h128, mk_ill(7'h11));
    send_a(32'h0000003B, 32'h12C, mk_ill(7'h3B));
    a_in_valid = 1'b0;
    drain_a();
    check("a_cnt_four_illegal", 64'(a_illegal_cnt), 64'd4);

    // Backpressure: two accepted, third held until downstream drains.
    a_out_ready = 1'b0;
    send_a(32'h00412283, 32'h200, mk(3'd1, 7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 64'h4, 1'b0));
    send_a(32'h123452B7, 32'h204, mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000, 1'b0));
    check("bp_in_ready_full", 64'(a_in_ready), 64'd0);
    fork
      send_a(32'h402081B3, 32'h208, mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'd0, 1'b0));
      begin
        for (int i = 0; i < 3; i++) begin
          cyc();
          check("bp_stall_out_pc",    64'(a_out_pc),    64'h200);
          check("bp_stall_in_ready",  64'(a_in_ready),  64'd0);
          check("bp_stall_out_valid", 64'(a_out_valid), 64'd1);
        end
        a_out_ready = 1'b1;
      end
    join
    a_in_valid = 1'b0;
    drain_a();

    // Flush with two entries buffered and input offered.
    a_out_ready = 1'b0;
    send_a(32'h00000000, 32'h300, mk_ill(7'h00));
    send_a(32'h00000000, 32'h304, mk_ill(7'h00));
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_instr = 32'h00000000; a_in_pc = 32'h308;
    q_a.delete();
    cyc();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("flush2_out_valid", 64'(a_out_valid),   64'd0);
    check("flush2_in_ready",  64'(a_in_ready),    64'd1);
    check("flush2_cnt",       64'(a_illegal_cnt), 64'd4);
    a_out_ready = 1'b1;
    repeat (3) cyc();
    check("flush2_no_delivery", 64'(a_out_valid), 64'd0);

    // Flush beats a simultaneous accept with one entry buffered.
    a_out_ready = 1'b0;
    send_a(32'hFFF00093, 32'h400, mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF, 1'b0));
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_instr = 32'h00000000; a_in_pc = 32'h404;
    q_a.delete();
    cyc();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("flush1_out_valid", 64'(a_out_valid), 64'd0);
    a_out_ready = 1'b1;
    repeat (3) cyc();
    check("flush1_dropped",   64'(a_out_valid),   64'd0);
    check("flush1_cnt",       64'(a_illegal_cnt), 64'd4);

    // Asynchronous reset mid-transfer.
    a_out_ready = 1'b0;
    send_a(32'h00000000, 32'h500, mk_ill(7'h00));
    send_a(32'h008000EF, 32'h504, mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h8, 1'b0));
    a_in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    q_a.delete();
    check("mid_rst_out_valid", 64'(a_out_valid),   64'd0);
    check("mid_rst_in_ready",  64'(a_in_ready),    64'd0);
    check("mid_rst_cnt",       64'(a_illegal_cnt), 64'd0);
    check("mid_rst_out_pc",    64'(a_out_pc),      64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    check("mid_rst_in_ready_back", 64'(a_in_ready),  64'd1);
    check("mid_rst_empty",         64'(a_out_valid), 64'd0);

    // RV64 instance: wide immediates, RV64-only opcodes, saturating 2-bit counter.
    b_out_ready = 1'b1;
    send_b(32'h800000B7, 64'h8000_0000_0000_1000,
           mk(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_8000_0000, 1'b0));
    send_b(32'h0000003B, 64'h8000_0000_0000_1004,
           mk(3'd0, 7'h3B, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b0));
    send_b(32'hFFF00093, 64'h8000_0000_0000_1008,
           mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0));
    send_b(32'h0000001B, 64'h8000_0000_0000_100C,
           mk(3'd1, 7'h1B, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b0));
    send_b(32'h00000000, 64'h10, mk_ill(7'h00));
    send_b(32'h00000000, 64'h14, mk_ill(7'h00));
    b_in_valid = 1'b0;
    drain_b();
    check("b_cnt_two", 64'(b_illegal_cnt), 64'd2);
    for (int i = 0; i < 3; i++) begin
      send_b(32'h00000000, 64'h18 + 64'(4 * i), mk_ill(7'h00));
    end
    b_in_valid = 1'b0;
    drain_b();
    check("b_cnt_saturated", 64'(b_illegal_cnt), 64'd3);

    check("a_scoreboard_empty", 64'(q_a.size()), 64'd0);
    check("b_scoreboard_empty", 64'(q_b.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
